// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C controller. Issues START, {addr,rw}, one data
// byte (write or read), both ACK slots and STOP on open-drain SCL/SDA.
// Every bus slot is four quarters of CLK_DIV clocks.
// Optional feature: define CLOCK_STRETCH_EN to freeze the quarter timing while
// a target holds SCL low during Q2 of a data/ACK slot.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;

    logic       data_slot;
    logic       stall;
    logic       qtr_end;
    logic       slot_end;
    logic       sample;

    // Slot classification and per-clock timing strobes
    always_comb begin
        data_slot = (state_q == S_ADDR) || (state_q == S_ACK_A) ||
                    (state_q == S_DATA) || (state_q == S_ACK_D);
`ifdef CLOCK_STRETCH_EN
        // SCL released by us but still low: the target is stretching.
        stall = data_slot && (qtr_q == 2'd2) && !scl_in && scl_out;
`else
        // Fixed timing; scl_in plays no part.
        stall = 1'b0 & scl_in;
`endif
        qtr_end  = (div_q == DIV_LAST) && !stall;
        slot_end = qtr_end && (qtr_q == 2'd3);
        sample   = data_slot && qtr_end && (qtr_q == 2'd2);
    end

    // Bus line levels derived from the current state, quarter and shift data
    always_comb begin
        scl_out = 1'b1;
        sda_out = 1'b1;
        case (state_q)
            S_START: begin
                sda_out = (qtr_q == 2'd0);
                scl_out = (qtr_q != 2'd3);
            end
            S_ADDR: begin
                scl_out = qtr_q[1];
                sda_out = tx_q[7];
            end
            S_DATA: begin
                scl_out = qtr_q[1];
                sda_out = rw_q | tx_q[7];   // released while reading
            end
            S_ACK_A, S_ACK_D: begin
                scl_out = qtr_q[1];         // SDA released (read ACK_D = NACK)
            end
            S_STOP: begin
                sda_out = qtr_q[1];
                scl_out = (qtr_q != 2'd0);
            end
            default: ;
        endcase
    end

    // Next-state logic: accept, quarter timing, sampling and slot sequencing
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_START;
                tx_d      = {addr, rw};
                rw_d      = rw;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
                div_d     = 8'd0;
                qtr_d     = 2'd0;
                bit_d     = 3'd0;
            end
        end else begin
            if (!stall) begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    qtr_d = qtr_q + 2'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            if (sample) begin
                if (state_q == S_ACK_A && sda_in)
                    ack_err_d = 1'b1;
                if (state_q == S_ACK_D && !rw_q && sda_in)
                    ack_err_d = 1'b1;
                if (state_q == S_DATA && rw_q)
                    rdata_d = {rdata_q[6:0], sda_in};
            end

            if (slot_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_ADDR;
                        bit_d   = 3'd0;
                    end
                    S_ADDR: begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_d = S_ACK_A;
                    end
                    S_ACK_A: begin
                        // ack_err was cleared on accept, so here it only
                        // reflects the address acknowledge.
                        if (ack_err_q) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_DATA;
                            tx_d    = wdata_q;
                            bit_d   = 3'd0;
                        end
                    end
                    S_DATA: begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_d = S_ACK_D;
                    end
                    S_ACK_D: state_d = S_STOP;
                    S_STOP: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State and datapath registers; reset releases both lines at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            tx_q      <= 8'd0;
            wdata_q   <= 8'd0;
            rw_q      <= 1'b0;
            rdata_q   <= 8'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C controller; the initiating end of the bus that the existing I2C slave responds to.
- Generates START, the 7-bit address plus R/W, one data byte (write or read), the ACK slots and STOP on open-drain SCL/SDA.
- Used on-chip and in benches to drive the slave, and as the controller for off-chip I2C peripherals.
- Pins map to uio with oe = !out for each line.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period; legal range 2..255. SCL period is 4*CLK_DIV clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  transaction request; sampled every cycle, accepted only when busy=0
- rw  in  1  1=read, 0=write; captured on accept
- addr  in  7  target address; captured on accept
- wdata  in  8  write byte; captured on accept
- scl_in  in  1  SCL line level, already synchronized by the integrator
- sda_in  in  1  SDA line level, already synchronized
- scl_out  out  1  0=drive SCL low, 1=release
- sda_out  out  1  0=drive SDA low, 1=release
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  target NACKed the address or the write data; valid from done until the next accept
- rdata  out  8  byte read; valid from done until the next accept

Behaviour:
Reset:
- Asynchronous.
- scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, rdata=0x00, FSM=IDLE, quarter counter=0.
- Reset mid-transaction releases both lines immediately. No STOP is generated.

Timing:
- Each bus slot is 4 quarters Q0..Q3 of CLK_DIV clocks each.
- The quarter counter runs only while busy=1.

Accept:
- start=1 with busy=0 (including the cycle done is high) captures addr, rw and wdata, clears ack_err, and sets busy the next cycle.
- start while busy=1 is ignored.

States and slots, in order:
- START: SDA/SCL per quarter Q0 1/1, Q1 0/1, Q2 0/1, Q3 0/0.
- ADDR: 8 slots, shifting out {addr,rw} MSB first.
- ACK_A: 1 slot.
- DATA: 8 slots.
- ACK_D: 1 slot.
- STOP: SDA/SCL per quarter Q0 0/0, Q1 0/1, Q2 1/1, Q3 1/1.

Data slot (ADDR/DATA/ACK):
- Q0–Q1: SCL low; SDA is updated at the start of Q0.
- Q2–Q3: SCL released.
- sda_in is sampled on the last clock of Q2.

Master SDA ownership:
- ADDR and write DATA: master drives the bit.
- ACK_A and write ACK_D: master releases SDA; sampled 1 sets ack_err.
- Read DATA: master releases SDA and shifts the sampled bits into rdata MSB first.
- Read ACK_D: master drives 1 (NACK, end of single-byte read).

Transitions:
- ACK_A NACK goes directly to STOP, skipping DATA and ACK_D; rdata is unchanged.
- A NACK in write ACK_D still proceeds to STOP.

End of transaction:
- After STOP Q3: busy=0 and done=1 for exactly one cycle; FSM returns to IDLE.
- Full transaction: busy high for exactly 80*CLK_DIV cycles (20 slots).
- Address NACK: busy high for exactly 44*CLK_DIV cycles (11 slots).

Idle:
- Both lines released.
- scl_in and sda_in are ignored outside their sample points.

Optional Feature:
CLOCK_STRETCH_EN:
- When defined: during Q2 of every data or ACK slot, the quarter counter is frozen for every cycle that scl_in=0 while scl_out=1. This honours target clock stretching. Transaction length grows by exactly the number of frozen cycles.
- When undefined: scl_in is unused and timing is fixed.

Test Plan:
- CLK_DIV=4: write addr=0x50, wdata=0xA5, model ACKs both -> SDA bits 1010000 0 then 10100101. busy high exactly 320 cycles, done pulse, ack_err=0.
- Read addr=0x50, model returns 0x3C -> rdata=0x3C at done. Master releases SDA in the 8 data slots and drives 1 in ACK_D. ack_err=0.
- Model NACKs the address -> STOP follows ACK_A, busy high exactly 176 cycles, ack_err=1, rdata unchanged from its previous value.
- start re-asserted mid-transaction and again in the done cycle -> first is ignored; second is accepted, busy=1 the next cycle, ack_err cleared.
- rst_n low during DATA slot 3 -> scl_out=1, sda_out=1, busy=0 in the same cycle; the next start runs a clean full transaction.
- CLOCK_STRETCH_EN defined, model holds SCL low 10 cycles in ADDR bit 0 Q2 -> write transaction busy 330 cycles. Macro undefined -> 320 cycles.
